// File: rtl/ifu_pkg.sv
// Shared types and widths for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } ifu_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched instruction words with their PCs.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_pi,
    input  logic                     reset_n_pi,
    input  logic                     push_pi,
    input  logic                     pop_pi,
    input  logic                     flush_pi,
    input  ifu_entry_t               wdata_pi,
    output ifu_entry_t               rdata_po,
    output logic [$clog2(DEPTH):0]   count_po,
    output logic                     full_po,
    output logic                     empty_po
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    ifu_entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]       count_q;
    logic                  do_push, do_pop;

    assign empty_po = (count_q == '0);
    assign full_po  = (count_q == CntW'(DEPTH));
    assign count_po = count_q;
    assign rdata_po = mem_q[rd_ptr_q];

    // A pop frees its slot before a same-cycle push needs it.
    assign do_pop  = pop_pi && !empty_po;
    assign do_push = push_pi && (!full_po || do_pop);

    always_ff @(posedge clk_pi) begin
        if (!reset_n_pi || flush_pi) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_pi) begin
        if (do_push && reset_n_pi && !flush_pi) mem_q[wr_ptr_q] <= wdata_pi;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem read per PC, buffered into a small queue for decode.
// Optional misaligned-PC fault detection is enabled by defining IFU_ALIGN_CHECK_EN.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk_pi,
    input  logic               reset_n_pi,
    input  logic [ADDR_W-1:0]  pc_pi,
    output logic               pc_advance_po,
    input  logic               flush_pi,
    output logic               imem_req_po,
    output logic [ADDR_W-1:0]  imem_addr_po,
    input  logic               imem_gnt_pi,
    input  logic               imem_rvalid_pi,
    input  logic [INSTR_W-1:0] imem_rdata_pi,
    output logic               instr_valid_po,
    output logic [INSTR_W-1:0] instr_po,
    output logic [ADDR_W-1:0]  instr_pc_po,
    input  logic               instr_ready_pi,
    output logic               fetch_fault_po
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    ifu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                drop_q, drop_d;
    logic                fetch_attempt, fetch_blocked;
    logic [ADDR_W-1:0]   req_pc;

    ifu_entry_t          head;
    logic [CntW-1:0]     fifo_count, count_after;
    logic                fifo_full, fifo_empty;
    logic                push, pop, room_after;

    assign pop  = instr_valid_po && instr_ready_pi;
    assign push = imem_rvalid_pi && !drop_q && (state_q == StWait);

    assign count_after = fifo_count + CntW'(push) - CntW'(pop);
    assign room_after  = count_after < CntW'(DEPTH);

`ifdef IFU_ALIGN_CHECK_EN
    logic fault_q;

    assign fetch_blocked  = fault_q || pc_pi[0];
    assign req_pc         = pc_pi;
    assign fetch_fault_po = fault_q;

    always_ff @(posedge clk_pi) begin
        if (!reset_n_pi || flush_pi) begin
            fault_q <= 1'b0;
        end else if (fetch_attempt && pc_pi[0]) begin
            fault_q <= 1'b1;
        end
    end
`else
    logic unused_fetch_attempt;

    assign unused_fetch_attempt = fetch_attempt;
    assign fetch_blocked        = 1'b0;
    assign req_pc               = {pc_pi[ADDR_W-1:1], 1'b0};
    assign fetch_fault_po       = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        drop_d        = drop_q;
        imem_req_po   = 1'b0;
        fetch_attempt = 1'b0;

        // A discarded response is consumed whatever state it lands in.
        if (imem_rvalid_pi && drop_q) drop_d = 1'b0;

        unique case (state_q)
            StIdle: fetch_attempt = !fifo_full && !flush_pi;
            StReq: begin
                imem_req_po = 1'b1;
                if (imem_gnt_pi) begin
                    state_d = StWait;
                    if (flush_pi) drop_d = 1'b1;
                end else if (flush_pi) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (flush_pi && !imem_rvalid_pi) drop_d = 1'b1;
                if (imem_rvalid_pi) begin
                    state_d       = StIdle;
                    fetch_attempt = room_after && !flush_pi;
                end
            end
            default: state_d = StIdle;
        endcase

        if (fetch_attempt && !fetch_blocked) begin
            state_d = StReq;
            addr_d  = req_pc;
        end
    end

    always_ff @(posedge clk_pi) begin
        if (!reset_n_pi) begin
            state_q <= StIdle;
            addr_q  <= '0;
            // An abandoned read may still return; swallow it.
            drop_q  <= (state_q == StWait);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_pi     (clk_pi),
        .reset_n_pi (reset_n_pi),
        .push_pi    (push),
        .pop_pi     (pop),
        .flush_pi   (flush_pi),
        .wdata_pi   ('{instr: imem_rdata_pi, pc: addr_q}),
        .rdata_po   (head),
        .count_po   (fifo_count),
        .full_po    (fifo_full),
        .empty_po   (fifo_empty)
    );

    assign pc_advance_po  = (imem_req_po && imem_gnt_pi) || flush_pi;
    assign imem_addr_po   = addr_q;
    assign instr_valid_po = !fifo_empty;
    assign instr_po       = instr_valid_po ? head.instr : '0;
    assign instr_pc_po    = instr_valid_po ? head.pc : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: bench acts as PC and imem, scoreboard holds expected words.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH = 2;

    logic        clk_pi = 1'b0;
    logic        reset_n_pi = 1'b0;
    logic [15:0] pc_pi = '0;
    logic        pc_advance_po;
    logic        flush_pi = 1'b0;
    logic        imem_req_po;
    logic [15:0] imem_addr_po;
    logic        imem_gnt_pi = 1'b0;
    logic        imem_rvalid_pi = 1'b0;
    logic [15:0] imem_rdata_pi = '0;
    logic        instr_valid_po;
    logic [15:0] instr_po;
    logic [15:0] instr_pc_po;
    logic        instr_ready_pi = 1'b0;
    logic        fetch_fault_po;

    instr_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk_pi         (clk_pi),
        .reset_n_pi     (reset_n_pi),
        .pc_pi          (pc_pi),
        .pc_advance_po  (pc_advance_po),
        .flush_pi       (flush_pi),
        .imem_req_po    (imem_req_po),
        .imem_addr_po   (imem_addr_po),
        .imem_gnt_pi    (imem_gnt_pi),
        .imem_rvalid_pi (imem_rvalid_pi),
        .imem_rdata_pi  (imem_rdata_pi),
        .instr_valid_po (instr_valid_po),
        .instr_po       (instr_po),
        .instr_pc_po    (instr_pc_po),
        .instr_ready_pi (instr_ready_pi),
        .fetch_fault_po (fetch_fault_po)
    );

    always #5 clk_pi = ~clk_pi;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: words decode should see, oldest first, as {instr, pc}.
    logic [31:0] exp_q[$];

    // Memory model: at most one read in flight.
    bit          mem_busy = 0, mem_drop = 0;
    logic [15:0] mem_addr = '0;
    int          mem_delay = 0;
    logic [15:0] salt = 16'h1234;
    logic [15:0] pc_nxt = '0;

    int          gnt_pct = 100, ready_pct = 0, flush_pm = 0, min_delay = 0, max_delay = 0;
    bit          force_flush = 0;
    logic [15:0] flush_target = '0;

    bit          prev_req, prev_gnt, prev_flush, prev_valid, prev_ready;
    logic [15:0] prev_addr, prev_instr, prev_ipc;
    bit          last_req, last_adv, last_valid, last_fault, gnt_seen;
    logic [15:0] last_instr, last_ipc, gnt_seen_addr;

    task automatic clear_prev();
        prev_req = 0; prev_gnt = 0; prev_flush = 0; prev_valid = 0; prev_ready = 0;
    endtask

    task automatic cycle();
        @(negedge clk_pi);
        pc_pi          = pc_nxt;
        imem_gnt_pi    = imem_req_po && !mem_busy && ($urandom_range(99) < gnt_pct);
        imem_rvalid_pi = mem_busy && (mem_delay == 0);
        imem_rdata_pi  = imem_rvalid_pi ? ((mem_addr * 16'd3) ^ salt) : 16'($urandom);
        flush_pi       = force_flush || ($urandom_range(999) < flush_pm);
        instr_ready_pi = $urandom_range(99) < ready_pct;
        #1;
        check("pc_advance", pc_advance_po, (imem_req_po && imem_gnt_pi) || flush_pi);
        check("instr_valid", instr_valid_po, exp_q.size() != 0);
        if (exp_q.size() != 0) check("head", {instr_po, instr_pc_po}, exp_q[0]);
        if (imem_req_po) check("req_room", exp_q.size() < DEPTH, 1);
        if (prev_flush) check("req_after_flush", imem_req_po, 0);
        if (prev_req && !prev_gnt && !prev_flush) begin
            check("req_hold", imem_req_po, 1);
            check("addr_hold", imem_addr_po, prev_addr);
        end
        if (imem_gnt_pi) check("gnt_addr", imem_addr_po, pc_pi);
        if (prev_valid && !prev_ready && !prev_flush)
            check("stall_hold", {instr_valid_po, instr_po, instr_pc_po},
                  {1'b1, prev_instr, prev_ipc});
`ifndef IFU_ALIGN_CHECK_EN
        check("fault_tied", fetch_fault_po, 0);
`endif
        last_req = imem_req_po; last_adv = pc_advance_po; last_valid = instr_valid_po;
        last_instr = instr_po; last_ipc = instr_pc_po; last_fault = fetch_fault_po;
        if (imem_gnt_pi) begin
            gnt_seen = 1; gnt_seen_addr = imem_addr_po;
        end

        // Effects of the coming edge: pop, then flush, then push.
        if (instr_valid_po && instr_ready_pi && exp_q.size() != 0) void'(exp_q.pop_front());
        if (flush_pi) begin
            exp_q.delete();
            if (mem_busy) mem_drop = 1;
        end
        if (imem_rvalid_pi) begin
            if (!mem_drop && !flush_pi) exp_q.push_back({imem_rdata_pi, mem_addr});
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_delay--;
        end
        if (imem_gnt_pi) begin
            mem_busy = 1; mem_addr = imem_addr_po; mem_drop = flush_pi;
            mem_delay = $urandom_range(max_delay, min_delay);
        end
        if (flush_pi) pc_nxt = force_flush ? flush_target : (16'($urandom) & 16'hFFFE);
        else if (pc_advance_po) pc_nxt = pc_pi + 16'd2;

        prev_req = imem_req_po; prev_gnt = imem_gnt_pi; prev_flush = flush_pi;
        prev_addr = imem_addr_po; prev_valid = instr_valid_po; prev_ready = instr_ready_pi;
        prev_instr = instr_po; prev_ipc = instr_pc_po;
        force_flush = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_pi);
        reset_n_pi = 0; imem_gnt_pi = 0; imem_rvalid_pi = 0; flush_pi = 0; instr_ready_pi = 0;
        @(posedge clk_pi);
        #1;
        exp_q.delete();
        if (mem_busy) mem_drop = 1;
        check("rst_req", imem_req_po, 0);
        check("rst_valid", instr_valid_po, 0);
        check("rst_instr", {instr_po, instr_pc_po}, 0);
        check("rst_addr", imem_addr_po, 0);
        check("rst_fault", fetch_fault_po, 0);
        check("rst_adv", pc_advance_po, 0);
        reset_n_pi = 1;
        clear_prev();
    endtask

    initial begin
        clear_prev();
        do_reset();

        // First fetch at earliest timing, decode stalled.
        cycle(); check("t1_idle", last_req, 0);
        cycle(); check("t1_req", last_req, 1); check("t1_adv", last_adv, 1);
        cycle(); check("t1_no_bypass", last_valid, 0); check("t1_adv_off", last_adv, 0);
        cycle(); check("t1_valid", last_valid, 1);
        check("t1_instr", last_instr, 16'h1234); check("t1_pc", last_ipc, 16'h0000);
        repeat (4) cycle();
        check("full_no_req", last_req, 0); check("full_no_adv", last_adv, 0);
        check("full_head_pc", last_ipc, 16'h0000);

        // Drain, then a grant delayed by three cycles.
        ready_pct = 100; gnt_pct = 0; min_delay = 1; max_delay = 1;
        for (int i = 0; i < 10 && !(last_req && exp_q.size() == 0); i++) cycle();
        check("delay_req_seen", last_req, 1);
        repeat (3) cycle();
        check("delay_req_held", last_req, 1);
        gnt_pct = 100;
        cycle(); check("delay_gnt_adv", last_adv, 1);

        // Flush while waiting: the returning word is dropped, refetch from target.
        salt = 16'hDEAD ^ (mem_addr * 16'd3);
        force_flush = 1; flush_target = 16'h0040;
        cycle();
        cycle(); check("flush_empty", last_valid, 0);
        min_delay = 0; max_delay = 0; gnt_seen = 0;
        for (int i = 0; i < 10 && !gnt_seen; i++) cycle();
        check("refetch_addr", gnt_seen_addr, 16'h0040);

`ifdef IFU_ALIGN_CHECK_EN
        pc_nxt = 16'h0003;
        do_reset();
        repeat (3) cycle();
        check("fault_set", last_fault, 1); check("fault_no_req", last_req, 0);
        force_flush = 1; flush_target = 16'h0010;
        cycle(); cycle();
        check("fault_clear", last_fault, 0);
`endif

        for (int r = 0; r < 3000; r++) begin
            if (r % 200 == 0) begin
                gnt_pct = $urandom_range(100, 30); ready_pct = $urandom_range(100, 20);
                flush_pm = $urandom_range(60, 0); max_delay = $urandom_range(3, 0);
                salt = 16'($urandom);
            end
            if (r % 500 == 250) do_reset();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
